// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment lookup for the scan driver
package seg7_pkg;

  // All segments and the decimal point dark on the active-low bus
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high g..a pattern for each hex digit 0..F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high a..g decode
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; the caller inverts for the active-low bus
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit hex 7-segment scan driver
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzb_en,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [FRM_W-1:0]    frame_cnt;
  logic                phase;
  logic                tick;
  logic                idx_wrap;

  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [DIGITS-1:0]   blink_sh;

  logic [DIGITS-1:0]   nz_prefix;
  logic                nz_running;
  logic [DIGITS-1:0]   digit_onehot;
  logic [3:0]          cur_nibble;
  logic [6:0]          dec_seg;
  logic                dark;
  logic                lzb_dark;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  assign tick       = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_wrap   = (idx == IDX_W'(DIGITS - 1));
  assign cur_nibble = data_sh[4*idx +: 4];

  // Slot prescaler: one tick every SCAN_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Digit index advances once per slot and wraps at the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      if (idx_wrap) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Count completed frames; flip blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick && idx_wrap) begin
      if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end
  end

  // Shadow registers: the display only ever shows what was loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      blink_sh <= '0;
    end else if (load) begin
      data_sh  <= data;
      dp_sh    <= dp;
      blank_sh <= blank;
      blink_sh <= blink;
    end
  end

  // Prefix-OR from the MSB: nz_prefix[i] is set when nibble i or any higher one is nonzero
  always_comb begin
    nz_prefix  = '0;
    nz_running = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_running   = nz_running | (|data_sh[4*i +: 4]);
      nz_prefix[i] = nz_running;
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Next output: anti-ghost gap on tick, else the selected digit with masking applied
  always_comb begin
    seg_d        = SEG_OFF;
    an_d         = '1;
    digit_onehot = '0;
    digit_onehot[idx] = 1'b1;
    dark         = blank_sh[idx] | (blink_sh[idx] & phase);
    lzb_dark     = lzb_en & (idx != '0) & ~nz_prefix[idx];
    if (!tick) begin
      an_d = ~digit_onehot;
      if (!dark) begin
        seg_d[7] = ~dp_sh[idx];
        if (!lzb_dark) begin
          seg_d[6:0] = ~dec_seg;
        end
      end
    end
  end

  // Registered outputs so the segment and anode buses switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_OFF;
      an_n  <= '1;
    end else begin
      seg_n <= seg_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [15:0]   data;
  logic [3:0]    dp;
  logic [3:0]    blank;
  logic [3:0]    blink;
  logic          lzb_en;
  logic [7:0]    seg_n;
  logic [3:0]    an_n;

  int checks;
  int errors;

  // Reference model state: edges since reset release and the loaded values
  int          m_k;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_driver #(
    .DIGITS       (D),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data   (data),
    .dp     (dp),
    .blank  (blank),
    .blink  (blink),
    .lzb_en (lzb_en),
    .seg_n  (seg_n),
    .an_n   (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the next edge, derived from absolute time since reset
  task automatic expect_next(output logic [7:0] es, output logic [3:0] ea);
    int c, s, id, ph;
    logic [3:0] nib;
    c  = m_k % SD;
    s  = m_k / SD;
    id = s % D;
    ph = (s / D / BF) % 2;
    es = 8'hFF;
    ea = 4'hF;
    if (c != SD - 1) begin
      ea = ~(4'b0001 << id);
      if (!(m_blank[id] || (m_blink[id] && ph == 1))) begin
        nib   = 4'((m_data >> (4 * id)) & 16'hF);
        es[7] = ~m_dp[id];
        if (lzb_en && id != 0 && (m_data >> (4 * id)) == 16'h0)
          es[6:0] = 7'h7F;
        else
          es[6:0] = ~hex_tab[nib];
      end
    end
  endtask

  // One clock: predict, clock, update model shadows, settle
  task automatic advance(output logic [7:0] es, output logic [3:0] ea);
    expect_next(es, ea);
    @(posedge clk);
    if (load) begin
      m_data  = data;
      m_dp    = dp;
      m_blank = blank;
      m_blink = blink;
    end
    m_k = m_k + 1;
    #1;
    load = 1'b0;
  endtask

  task automatic model_reset();
    m_k     = 0;
    m_data  = '0;
    m_dp    = '0;
    m_blank = '0;
    m_blink = '0;
  endtask

  task automatic test_reset();
    logic [7:0] es;
    logic [3:0] ea;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg_n !== 8'hFF || an_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_hold seg_n=%h an_n=%b required FF 1111", seg_n, an_n);
    end
    rst_n = 1'b1;
    model_reset();
    advance(es, ea);
    checks++;
    if (seg_n !== 8'hC0 || an_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_first_edge seg_n=%h an_n=%b required C0 1110", seg_n, an_n);
    end
    for (int i = 0; i < 20; i++) begin
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL reset_zero_scan k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
  endtask

  task automatic test_scan_pattern();
    logic [7:0] es;
    logic [3:0] ea;
    logic [7:0] want_seg [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
    logic [3:0] want_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    data = 16'h1A3F; dp = 4'h0; blank = 4'h0; blink = 4'h0; lzb_en = 1'b0;
    load = 1'b1;
    advance(es, ea);
    // Walk to the edge that opens slot 0 of a frame, then check the fixed pattern
    while (m_k % (SD * D) != 0) advance(es, ea);
    for (int d = 0; d < D; d++) begin
      for (int c = 0; c < SD; c++) begin
        advance(es, ea);
        checks++;
        if (c < SD - 1) begin
          if (seg_n !== want_seg[d] || an_n !== want_an[d]) begin
            errors++;
            $display("FAIL scan_fixed d=%0d c=%0d seg_n=%h an_n=%b required %h %b", d, c, seg_n, an_n, want_seg[d], want_an[d]);
          end
        end else begin
          if (seg_n !== 8'hFF || an_n !== 4'hF) begin
            errors++;
            $display("FAIL scan_gap d=%0d seg_n=%h an_n=%b required FF 1111", d, seg_n, an_n);
          end
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] es;
    logic [3:0] ea;
    data = 16'h0050; dp = 4'b0100; blank = 4'h0; blink = 4'h0; lzb_en = 1'b1;
    load = 1'b1;
    for (int i = 0; i < 3 * SD * D; i++) begin
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL lzb_0050 k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
    data = 16'h0000; dp = 4'h0;
    load = 1'b1;
    for (int i = 0; i < 2 * SD * D; i++) begin
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL lzb_zero k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
  endtask

  task automatic test_blank_blink();
    logic [7:0] es;
    logic [3:0] ea;
    data = 16'h4321; dp = 4'h0; blank = 4'b0010; blink = 4'b0001; lzb_en = 1'b0;
    load = 1'b1;
    for (int i = 0; i < 9 * SD * D; i++) begin
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL blank_blink k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
  endtask

  task automatic test_load_on_tick();
    logic [7:0] es;
    logic [3:0] ea;
    data = 16'h0000; dp = 4'h0; blank = 4'h0; blink = 4'h0; lzb_en = 1'b0;
    load = 1'b1;
    advance(es, ea);
    while (m_k % (SD * D) != SD * D - 1) advance(es, ea);
    data = 16'h000F;
    load = 1'b1;
    advance(es, ea);
    checks++;
    if (seg_n !== 8'hFF || an_n !== 4'hF) begin
      errors++;
      $display("FAIL load_tick_gap seg_n=%h an_n=%b required FF 1111", seg_n, an_n);
    end
    advance(es, ea);
    checks++;
    if (seg_n !== es || an_n !== ea || seg_n !== 8'h8E || an_n !== 4'b1110) begin
      errors++;
      $display("FAIL load_tick_new seg_n=%h an_n=%b required 8E 1110", seg_n, an_n);
    end
  endtask

  task automatic test_random();
    logic [7:0] es;
    logic [3:0] ea;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        data  = 16'($urandom);
        if ($urandom_range(0, 1) == 1) data = data >> (4 * $urandom_range(1, 3));
        dp    = 4'($urandom);
        blank = 4'($urandom) & 4'($urandom);
        blink = 4'($urandom);
        load  = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL random k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] es;
    logic [3:0] ea;
    data = 16'h9876; dp = 4'b1111; blank = 4'h0; blink = 4'b0001; lzb_en = 1'b0;
    load = 1'b1;
    advance(es, ea);
    while (m_k % (SD * D) != 9) advance(es, ea);
    checks++;
    if (an_n !== 4'b1011) begin
      errors++;
      $display("FAIL reset_mid_pre an_n=%b required 1011", an_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg_n !== 8'hFF || an_n !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_async seg_n=%h an_n=%b required FF 1111", seg_n, an_n);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    advance(es, ea);
    checks++;
    if (seg_n !== 8'hC0 || an_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_mid_restart seg_n=%h an_n=%b required C0 1110", seg_n, an_n);
    end
    blink = 4'b0001; blank = 4'h0; dp = 4'h0; data = 16'h0007;
    load = 1'b1;
    for (int i = 0; i < 3 * SD * D; i++) begin
      advance(es, ea);
      checks++;
      if (seg_n !== es || an_n !== ea) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d seg_n=%h an_n=%b required %h %b", m_k, seg_n, an_n, es, ea);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    data   = '0;
    dp     = '0;
    blank  = '0;
    blink  = '0;
    lzb_en = 1'b0;
    model_reset();
    test_reset();
    test_scan_pattern();
    test_lzb();
    test_blank_blink();
    test_load_on_tick();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, multiplexed N-digit hex 7-segment display driver. It latches a packed hex word plus per-digit decimal-point, blank and blink masks, then time-multiplexes one shared active-low segment bus across DIGITS active-low digit enables. It adds leading-zero blanking, blinking and an anti-ghost gap, and it is the display back end for all board-level numeric output in the final project.

## Interface
- DIGITS, 8, number of digits; legal 1..16.
- SCAN_DIV, 50000, clk cycles per digit slot; legal ≥2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; legal ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data/dp/blank/blink into shadow registers.
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i], digit 0 rightmost.
- dp  in  DIGITS  decimal point on per digit, active-high.
- blank  in  DIGITS  force digit dark, active-high.
- blink  in  DIGITS  digit dark during blink-off phase, active-high.
- lzb_en  in  1  leading-zero blanking enable, level, not latched.
- seg_n  out  8  active-low segments, [0]=a … [6]=g, [7]=dp.
- an_n  out  DIGITS  active-low digit enables, one-hot-low or all-high.

## Operation
- Shadow registers reset to 0 and update only on clocks with load=1; display always reflects shadow, never live inputs.
- Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (count==SCAN_DIV-1).
- Digit index idx counts 0..DIGITS-1, advances on tick, and wraps DIGITS-1→0. DIGITS=1 keeps idx=0.
- Blink phase bit toggles on the tick that wraps idx to 0 after BLINK_FRAMES frames. A frame counter counts wraps, and the phase starts at 0 = on.
- Hex decode, active-high g..a: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg_n[6:0] is the inverse.
- Dark digit, when blank[idx], or blink[idx] with phase=1: seg_n=8'hFF; an_n still selects idx.
- LZB with lzb_en=1: digit i≥1 has a–g dark when nibble i and every higher nibble are 0. Digit 0 is never LZB-blanked. dp still follows dp[i].
- seg_n[7] = ~dp[idx] unless dark.

## Timing
- Reset, asynchronous: seg_n=8'hFF, an_n=all ones, idx=0, prescaler=0, frame counter=0, phase=0, shadows=0.
- seg_n/an_n are registers recomputed every cycle from current idx/shadow/phase. Output latency is 1 cycle after any state change.
- Anti-ghost: on the cycle after each tick, an_n=all ones and seg_n=8'hFF. Each digit is therefore lit SCAN_DIV-1 cycles per slot.
- First edge after rst_n release: an_n selects digit 0 with shadow=0. The display shows "0" on digit 0, or all zeros with lzb_en=0.
- load coincident with tick: shadow and idx both update on that edge. The next lit cycle uses the new data.
- load mid-slot: the current digit changes on the following cycle; no wait for a frame boundary.
- rst_n asserted mid-frame blanks outputs immediately and restarts at digit 0.

## Structure
- seg7_pkg: constant hex→segment table, function hex_to_seg(nibble) returning active-high a–g, and SEG_OFF=8'hFF.
- Sub-module seg7_hex_decode: combinational nibble→7-bit, single instance fed by the muxed nibble.
- Top: prescaler, idx, frame/phase counters, shadow registers, LZB mask logic (DIGITS-bit prefix-OR from MSB), output register.

## Test plan
- DIGITS=4, SCAN_DIV=4, load data=16'h1A3F, lzb_en=0 → an_n cycles 1110,1101,1011,0111. seg_n[6:0]=~7'h71, ~7'h4F, ~7'h77, ~7'h06. Each digit is lit 3 cycles after a 1-cycle all-ones gap.
- data=16'h0050, lzb_en=1, dp=4'b0100 → digits 3 dark with seg_n=FF. Digit 2 shows ~7'h00 with seg_n[7]=0. Digit 1 shows 5, digit 0 shows 0. With data=0, digit 0 shows 0 and the others are dark.
- blank=4'b0010, blink=4'b0001, BLINK_FRAMES=2 → digit 1 always FF. Digit 0 alternates lit/dark every 2 frames, starting lit.
- load asserted on the same edge as tick with data changing 0→F at idx 0 → the first lit cycle of the new slot shows the new nibble.
- rst_n pulsed low mid-slot on digit 2 → outputs go FF/all ones asynchronously. After release, digit 0 is selected on the next edge, shadows are 0, and phase is 0.
